// File: rtl/pq_pkg.sv
// Shared definitions for the priority-queue command initiator and the
// cycled queue's bench: command opcodes, initiator states and default timing.
package pq_pkg;

    // Command opcodes as carried on the upstream command channel.
    typedef enum logic [1:0] {
        OP_PEEK = 2'b00,
        OP_ENQ  = 2'b01,
        OP_DEQ  = 2'b10,
        OP_REPL = 2'b11
    } pq_op_t;

    // Initiator control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } initiator_state_t;

    // Settle cycles the cycled queue needs after a dequeue or replace pulse.
    localparam int PQ_DEQ_WAIT_DEFAULT = 2;

    // Larger of two settle times; sizes the shared wait counter.
    function automatic int pq_max_wait(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pq_wait_counter.sv
// Loadable saturating down-counter with a terminal-count flag. The flag is
// high whenever the count is zero, so a load of N-1 yields N counting cycles.
module pq_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_tc
);

    logic [WIDTH-1:0] count_r;

    // Load takes priority; otherwise step down by one and stick at zero.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            count_r <= '0;
        end else if (i_load) begin
            count_r <= i_load_val;
        end else if (i_dec && (count_r != '0)) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign o_tc = (count_r == '0);

endmodule

// File: rtl/pq_cmd_initiator.sv
// Command-side initiator for the cycled register-array priority queue.
// Accepts one command at a time, pulses the queue for exactly one cycle,
// waits for the queue to settle and returns popped value and new top.
module pq_cmd_initiator
    import pq_pkg::*;
#(
    parameter int   QUEUE_SIZE = 64,
    parameter int   DATA_WIDTH = 16,
    parameter logic ENQ_ENA    = 1'b1,
    parameter int   ENQ_WAIT   = QUEUE_SIZE / 2,
    parameter int   DEQ_WAIT   = PQ_DEQ_WAIT_DEFAULT
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [DATA_WIDTH-1:0] o_rsp_top,
    output logic                  o_rsp_err,
    output logic                  o_pq_wrt,
    output logic                  o_pq_read,
    output logic [DATA_WIDTH-1:0] o_pq_data,
    input  logic                  i_pq_full,
    input  logic                  i_pq_empty,
    input  logic [DATA_WIDTH-1:0] i_pq_data
);

    localparam int MAX_WAIT = pq_max_wait(ENQ_WAIT, DEQ_WAIT);
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    // The counter flags terminal count at zero, so load one less than the
    // number of settle cycles wanted.
    localparam logic [CNT_W-1:0] ENQ_LOAD = CNT_W'(ENQ_WAIT - 1);
    localparam logic [CNT_W-1:0] DEQ_LOAD = CNT_W'(DEQ_WAIT - 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_RESP  = ST_RESP;

    logic [1:0]            state_r;
    logic [1:0]            next_state_s;
    pq_op_t                op_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  cmd_ready_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic [DATA_WIDTH-1:0] rsp_top_r;
    logic                  rsp_err_r;

    logic                  accept_s;
    logic                  illegal_s;
    logic                  pulse_s;
    logic                  wrt_s;
    logic                  read_s;
    logic [DATA_WIDTH-1:0] pq_data_s;
    logic [DATA_WIDTH-1:0] cur_top_s;
    logic [CNT_W-1:0]      load_val_s;
    logic                  tc_s;

    assign accept_s = cmd_ready_r & i_cmd_valid;

    // An empty queue reports its top as zero regardless of what the pins show.
    assign cur_top_s = i_pq_empty ? {DATA_WIDTH{1'b0}} : i_pq_data;

    // Legality from live queue status, and the single-cycle queue pulses.
    always_comb begin
        illegal_s  = 1'b0;
        pulse_s    = 1'b0;
        wrt_s      = 1'b0;
        read_s     = 1'b0;
        pq_data_s  = {DATA_WIDTH{1'b0}};
        load_val_s = DEQ_LOAD;
        case (op_r)
            OP_ENQ:  illegal_s = i_pq_full | ~ENQ_ENA;
            OP_DEQ:  illegal_s = i_pq_empty;
            default: illegal_s = 1'b0;
        endcase
        if (op_r == OP_ENQ) begin
            load_val_s = ENQ_LOAD;
        end else begin
            load_val_s = DEQ_LOAD;
        end
        if (state_r == S_ISSUE) begin
            pulse_s   = ~illegal_s & (op_r != OP_PEEK);
            wrt_s     = pulse_s & ((op_r == OP_ENQ) | (op_r == OP_REPL));
            read_s    = pulse_s & ((op_r == OP_DEQ) | (op_r == OP_REPL));
            pq_data_s = data_r;
        end else begin
            pulse_s   = 1'b0;
            wrt_s     = 1'b0;
            read_s    = 1'b0;
            pq_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Next-state selection for the command sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    next_state_s = S_ISSUE;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (pulse_s) begin
                    next_state_s = S_WAIT;
                end else begin
                    next_state_s = S_RESP;
                end
            end
            S_WAIT: begin
                if (tc_s) begin
                    next_state_s = S_RESP;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_RESP;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Settle timer, loaded on the pulse cycle and stepped while waiting.
    pq_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_load     (pulse_s),
        .i_load_val (load_val_s),
        .i_dec      (state_r == S_WAIT),
        .o_tc       (tc_s)
    );

    // State, command latch and registered response fields.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_r     <= S_IDLE;
            op_r        <= OP_PEEK;
            data_r      <= {DATA_WIDTH{1'b0}};
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_WIDTH{1'b0}};
            rsp_top_r   <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cmd_ready_r <= (next_state_s == S_IDLE);
            rsp_valid_r <= (next_state_s == S_RESP);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r   <= pq_op_t'(i_cmd_op);
                        data_r <= i_cmd_data;
                    end
                end
                S_ISSUE: begin
                    rsp_err_r <= illegal_s;
                    if (illegal_s) begin
                        rsp_data_r <= {DATA_WIDTH{1'b0}};
                        rsp_top_r  <= cur_top_s;
                    end else if (op_r == OP_PEEK) begin
                        rsp_data_r <= cur_top_s;
                        rsp_top_r  <= cur_top_s;
                    end else if (op_r == OP_ENQ) begin
                        rsp_data_r <= {DATA_WIDTH{1'b0}};
                    end else begin
                        // Pre-op top is the value the dequeue/replace pops.
                        rsp_data_r <= cur_top_s;
                    end
                end
                S_WAIT: begin
                    if (tc_s) begin
                        rsp_top_r <= cur_top_s;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_data_r <= {DATA_WIDTH{1'b0}};
                        rsp_top_r  <= {DATA_WIDTH{1'b0}};
                        rsp_err_r  <= 1'b0;
                    end
                end
                default: begin
                    rsp_err_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_ready = cmd_ready_r;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_data  = rsp_data_r;
    assign o_rsp_top   = rsp_top_r;
    assign o_rsp_err   = rsp_err_r;
    assign o_pq_wrt    = wrt_s;
    assign o_pq_read   = read_s;
    assign o_pq_data   = pq_data_s;

endmodule

// File: tb/tb_pq_cmd_initiator.sv
// Bench for pq_cmd_initiator: a behavioural max-first queue with settle delay
// answers the pulses, and expected responses come from the queue contents.
module tb_pq_cmd_initiator;

    localparam int QS = 8;
    localparam int EW = 4;
    localparam int DW = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic        cmd_valid, rsp_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_pq_wrt, o_pq_read;
    logic [15:0] o_rsp_data, o_rsp_top, o_pq_data;
    logic        pq_full  = 1'b0;
    logic        pq_empty = 1'b1;
    logic [15:0] pq_top   = 16'd0;

    logic        ne_cmd_valid;
    logic [1:0]  ne_cmd_op   = 2'd1;
    logic [15:0] ne_cmd_data;
    logic        ne_rsp_ready = 1'b1;
    logic        ne_pq_full   = 1'b0;
    logic        ne_pq_empty  = 1'b0;
    logic [15:0] ne_pq_data   = 16'd1234;
    logic        ne_cmd_ready, ne_rsp_valid, ne_rsp_err, ne_pq_wrt, ne_pq_read;
    logic [15:0] ne_rsp_data, ne_rsp_top, ne_pq_dout;

    int errors = 0;
    int checks = 0;
    int wrt_cnt = 0, read_cnt = 0, both_cnt = 0, ne_wrt_cnt = 0;
    logic [15:0] last_wrt_data = 16'd0;
    logic        smp_wrt = 1'b0, smp_read = 1'b0;
    logic [15:0] smp_data = 16'd0;
    int          busy = 0;
    logic [15:0] q[$];
    logic [52:0] all_out_s;

    assign all_out_s = {o_cmd_ready, o_rsp_valid, o_rsp_err, o_pq_wrt, o_pq_read,
                        o_rsp_data, o_rsp_top, o_pq_data};

    pq_cmd_initiator #(.QUEUE_SIZE(QS), .DATA_WIDTH(16), .ENQ_ENA(1'b1),
                       .ENQ_WAIT(EW), .DEQ_WAIT(DW)) u_dut (
        .i_CLK(CLK), .i_RST(RST), .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_data(cmd_data), .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(rsp_ready), .o_rsp_data(o_rsp_data), .o_rsp_top(o_rsp_top),
        .o_rsp_err(o_rsp_err), .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read),
        .o_pq_data(o_pq_data), .i_pq_full(pq_full), .i_pq_empty(pq_empty),
        .i_pq_data(pq_top));

    pq_cmd_initiator #(.QUEUE_SIZE(QS), .DATA_WIDTH(16), .ENQ_ENA(1'b0),
                       .ENQ_WAIT(EW), .DEQ_WAIT(DW)) u_dut_noenq (
        .i_CLK(CLK), .i_RST(RST), .i_cmd_valid(ne_cmd_valid), .o_cmd_ready(ne_cmd_ready),
        .i_cmd_op(ne_cmd_op), .i_cmd_data(ne_cmd_data), .o_rsp_valid(ne_rsp_valid),
        .i_rsp_ready(ne_rsp_ready), .o_rsp_data(ne_rsp_data), .o_rsp_top(ne_rsp_top),
        .o_rsp_err(ne_rsp_err), .o_pq_wrt(ne_pq_wrt), .o_pq_read(ne_pq_read),
        .o_pq_data(ne_pq_dout), .i_pq_full(ne_pq_full), .i_pq_empty(ne_pq_empty),
        .i_pq_data(ne_pq_data));

    // Pulse monitor: the queue samples its control pins on the rising edge.
    always @(posedge CLK) begin
        smp_wrt  <= o_pq_wrt;
        smp_read <= o_pq_read;
        smp_data <= o_pq_data;
        if (o_pq_wrt) begin
            wrt_cnt       <= wrt_cnt + 1;
            last_wrt_data <= o_pq_data;
        end
        if (o_pq_read) read_cnt <= read_cnt + 1;
        if (o_pq_wrt && o_pq_read) both_cnt <= both_cnt + 1;
        if (ne_pq_wrt) ne_wrt_cnt <= ne_wrt_cnt + 1;
    end

    function automatic void q_insert(input logic [15:0] d);
        int pos;
        pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] < d) begin
                pos = i;
                break;
            end
        end
        q.insert(pos, d);
    endfunction

    // Queue model: applies sampled pulses, shows garbage on the top pins
    // until the settle time has elapsed.
    always @(negedge CLK) begin
        if (smp_wrt || smp_read) begin
            if (smp_read && q.size() > 0) void'(q.pop_front());
            if (smp_wrt && q.size() < QS) q_insert(smp_data);
            busy = (smp_wrt && !smp_read) ? EW - 1 : DW - 1;
        end else if (busy > 0) begin
            busy--;
        end
        pq_full  = (q.size() == QS);
        pq_empty = (q.size() == 0);
        pq_top   = (busy > 0) ? 16'hBAD0 : ((q.size() > 0) ? q[0] : 16'd0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command through the full handshake, checked against the queue model.
    task automatic do_cmd(input logic [1:0] op, input logic [15:0] d, input int hold);
        int sz, lat, e_wrt, e_read, e_size, w0, r0, b0, k;
        logic [15:0] top0, sec0, e_data, e_top;
        logic e_err;
        sz   = q.size();
        top0 = (sz > 0) ? q[0] : 16'd0;
        sec0 = (sz > 1) ? q[1] : 16'd0;
        e_err = 1'b0; e_wrt = 0; e_read = 0; e_data = 16'd0; e_top = top0; lat = 1; e_size = sz;
        case (op)
            2'd0: e_data = top0;
            2'd1: if (sz >= QS) e_err = 1'b1;
                  else begin
                      e_wrt = 1; lat = 1 + EW; e_size = sz + 1;
                      e_top = (d > top0) ? d : top0;
                  end
            2'd2: if (sz == 0) e_err = 1'b1;
                  else begin
                      e_read = 1; lat = 1 + DW; e_size = sz - 1;
                      e_data = top0; e_top = sec0;
                  end
            default: begin
                e_wrt = 1; e_read = 1; lat = 1 + DW; e_data = top0;
                e_size = (sz == 0) ? 1 : sz;
                e_top  = (sz == 0) ? d : ((d > sec0) ? d : sec0);
            end
        endcase
        k = 0;
        @(negedge CLK);
        while (o_cmd_ready !== 1'b1 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("cmd_ready", o_cmd_ready, 1);
        w0 = wrt_cnt; r0 = read_cnt; b0 = both_cnt;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge CLK); #1;
        cmd_valid = 1'b0; cmd_data = 16'($urandom_range(0, 65535));
        for (k = 1; k <= 20; k++) begin
            @(posedge CLK); #1;
            if (o_rsp_valid === 1'b1) break;
        end
        chk("rsp_latency", k, lat);
        chk("rsp_fields", {o_rsp_err, o_rsp_data, o_rsp_top}, {e_err, e_data, e_top});
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            chk("rsp_hold", {o_rsp_valid, o_cmd_ready, o_rsp_err, o_rsp_data, o_rsp_top},
                {1'b1, 1'b0, e_err, e_data, e_top});
        end
        @(negedge CLK); rsp_ready = 1'b1;
        @(posedge CLK); #1; rsp_ready = 1'b0;
        chk("rsp_release", o_rsp_valid, 0);
        chk("pulse_count", {8'(wrt_cnt - w0), 8'(read_cnt - r0), 8'(both_cnt - b0)},
            {8'(e_wrt), 8'(e_read), 8'(e_wrt & e_read)});
        if (e_wrt == 1) chk("pq_data", last_wrt_data, d);
        chk("queue_size", q.size(), e_size);
    endtask

    initial begin
        int w0, k;
        logic seen;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 16'd0; rsp_ready = 1'b0;
        ne_cmd_valid = 1'b0; ne_cmd_data = 16'd0;
        #12;
        chk("reset_outputs", all_out_s, 0);
        @(negedge CLK); RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("ready_after_reset", o_cmd_ready, 1);
        @(posedge CLK); #3; RST = 1'b1; #1;
        chk("async_reset_outputs", all_out_s, 0);
        @(negedge CLK); RST = 1'b0;
        w0 = wrt_cnt + read_cnt; seen = 1'b0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0) seen = 1'b1;
        end
        chk("idle_ready", seen, 0);
        chk("idle_no_pulses", 8'(wrt_cnt + read_cnt - w0), 0);

        do_cmd(2'd2, 16'd0, 0);               // dequeue on empty queue
        do_cmd(2'd1, 16'd5, 0);               // enqueue 5 into empty queue
        for (int i = 0; i < 7; i++) do_cmd(2'd1, 16'($urandom_range(0, 65535)), 0);
        do_cmd(2'd1, 16'd7, 0);               // enqueue on full queue
        do_cmd(2'd0, 16'd0, 1);
        for (int i = 0; i < 8; i++) do_cmd(2'd2, 16'd0, 0);
        do_cmd(2'd0, 16'd0, 0);               // peek on empty queue
        do_cmd(2'd1, 16'd900, 0);
        do_cmd(2'd1, 16'd400, 0);
        do_cmd(2'd3, 16'd3, 0);               // replace with both pulses together
        do_cmd(2'd2, 16'd0, 10);              // long response back-pressure

        // Reset while the pulse is on the pins.
        @(negedge CLK);
        w0 = wrt_cnt; k = q.size();
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 16'd77;
        @(posedge CLK); #1; cmd_valid = 1'b0; #2;
        chk("issue_pulse", {o_pq_wrt, o_pq_data}, {1'b1, 16'd77});
        RST = 1'b1; #1;
        chk("issue_reset_drop", all_out_s, 0);
        @(negedge CLK); RST = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("issue_reset_no_pulse", {8'(wrt_cnt - w0), 8'(q.size())}, {8'd0, 8'(k)});

        // Reset while waiting for the queue to settle.
        @(negedge CLK);
        w0 = wrt_cnt; k = q.size();
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 16'd88;
        @(posedge CLK); #1; cmd_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #3; RST = 1'b1; #1;
        chk("wait_reset_outputs", all_out_s, 0);
        @(negedge CLK); RST = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (o_rsp_valid !== 1'b0) seen = 1'b1;
        end
        chk("wait_reset_no_rsp", {seen, o_cmd_ready}, {1'b0, 1'b1});
        chk("wait_reset_queue", {8'(wrt_cnt - w0), 8'(q.size())}, {8'd1, 8'(k + 1)});

        for (int n = 0; n < 40; n++)
            do_cmd(2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)),
                   int'($urandom_range(0, 3)));

        // Enqueue disabled: every enqueue is rejected without a pulse.
        for (int n = 0; n < 2; n++) begin
            @(negedge CLK);
            ne_cmd_valid = 1'b1; ne_cmd_data = 16'($urandom_range(0, 65535));
            @(posedge CLK); #1; ne_cmd_valid = 1'b0;
            for (k = 1; k <= 10; k++) begin
                @(posedge CLK); #1;
                if (ne_rsp_valid === 1'b1) break;
            end
            chk("noenq_latency", k, 1);
            chk("noenq_err", ne_rsp_err, 1);
            repeat (2) @(posedge CLK);
        end
        chk("noenq_no_pulse", ne_wrt_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
